wb_buttons_leds_slave: RTL and testbench

- Wishbone classic responder in the user project area; the management SoC is the initiator.
- Drives 8 LED pads on mprj_io[17:10] and samples 3 button pads on mprj_io[9:7].
- Buttons are synchronised and debounced, and rising edges are captured in a sticky register.
- LEDs are driven either from a software register or in hardware mirror mode, which the chip-level LED test uses.

---
 rtl/wb_buttons_leds_slave_pkg.sv | 13 +
 rtl/wb_buttons_leds_slave_if.sv | 23 ++
 rtl/wb_buttons_leds_slave_button_debounce.sv | 50 +++++
 rtl/wb_buttons_leds_slave.sv | 153 +++++++++++++++
 tb/tb_wb_buttons_leds_slave.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_buttons_leds_slave_pkg.sv
// Shared register map and control-bit definitions for the buttons/LEDs Wishbone slave.
package wb_buttons_leds_pkg;

  localparam logic [7:0] LED_OFF   = 8'h00;
  localparam logic [7:0] BTN_OFF   = 8'h04;
  localparam logic [7:0] EDGE_OFF  = 8'h08;
  localparam logic [7:0] CTRL_OFF  = 8'h0C;
  localparam logic [7:0] IMASK_OFF = 8'h10;

  localparam int MIRROR_BIT = 0;
  localparam int NUM_LEDS   = 8;

endpackage

// File: rtl/wb_buttons_leds_slave_if.sv
// Wishbone classic bus bundle between the management SoC (master) and this slave.
interface wb_buttons_leds_slave_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_buttons_leds_slave_button_debounce.sv
// One-bit button conditioner: 2-flop synchroniser followed by a stable-count debouncer.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic btn_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             syncMeta_q;
  logic             syncOut_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Any cycle where the synced input agrees with the stable value restarts the count.
  always_comb begin
    stable_d = stable_q;
    count_d  = '0;
    if (syncOut_q != stable_q) begin
      if (count_q == CNT_MAX) begin
        stable_d = syncOut_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      stable_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      syncMeta_q <= btn_i;
      syncOut_q  <= syncMeta_q;
      stable_q   <= stable_d;
      count_q    <= count_d;
    end
  end

  assign btn_o = stable_q;

endmodule

// File: rtl/wb_buttons_leds_slave.sv
// Wishbone classic slave driving 8 LEDs and sampling debounced buttons with sticky edge flags.
// Define WB_BUTTONS_IRQ_EN to add the IMASK register and a level interrupt on masked edges.
module wb_buttons_leds_slave
  import wb_buttons_leds_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter int          NUM_BUTTONS     = 3,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rstn_i,
  wb_buttons_leds_slave_if.slave     wbs,
  input  logic [NUM_BUTTONS-1:0]     buttons_i,
  output logic [NUM_LEDS-1:0]        leds_o,
  output logic [NUM_LEDS-1:0]        leds_oeb_o,
  output logic                       irq_o
);

  logic                   hit;
  logic                   access;
  logic                   wrEn;
  logic [7:0]             offset;
  logic [31:0]            rdData;
  logic [NUM_BUTTONS-1:0] btnDbnc;
  logic [NUM_BUTTONS-1:0] btnRise;
  logic [NUM_BUTTONS-1:0] edgeClr;
  logic [NUM_LEDS-1:0]    mirrorLeds;
  logic                   unusedBits;

  logic                   ack_q;
  logic                   ack_d;
  logic [31:0]            datOut_q;
  logic [31:0]            datOut_d;
  logic [NUM_LEDS-1:0]    led_q;
  logic [NUM_LEDS-1:0]    led_d;
  logic                   ctrlMirror_q;
  logic                   ctrlMirror_d;
  logic [NUM_BUTTONS-1:0] btnPrev_q;
  logic [NUM_BUTTONS-1:0] edgeFlags_q;
  logic [NUM_BUTTONS-1:0] edgeFlags_d;
  logic [NUM_LEDS-1:0]    leds_q;
  logic [NUM_LEDS-1:0]    leds_d;

  // A held strobe is acked every other cycle because the ack cycle itself never counts as an access.
  assign hit    = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access = hit & ~ack_q;
  assign wrEn   = access & wbs.wbs_we_i & wbs.wbs_sel_i[0];
  assign offset = {wbs.wbs_adr_i[7:2], 2'b00};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gen_dbnc
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dbnc (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rstn_i),
      .btn_i (buttons_i[i]),
      .btn_o (btnDbnc[i])
    );
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : gen_mirror
    assign mirrorLeds[k] = btnDbnc[k % NUM_BUTTONS];
  end

`ifdef WB_BUTTONS_IRQ_EN
  logic [NUM_BUTTONS-1:0] imask_q;
  logic [NUM_BUTTONS-1:0] imask_d;
  logic                   irq_q;

  always_comb begin
    imask_d = imask_q;
    if (wrEn && offset == IMASK_OFF) begin
      imask_d = wbs.wbs_dat_i[NUM_BUTTONS-1:0];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      imask_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      imask_q <= imask_d;
      irq_q   <= |(edgeFlags_q & imask_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdData = '0;
    case (offset)
      LED_OFF:   rdData[NUM_LEDS-1:0]    = led_q;
      BTN_OFF:   rdData[NUM_BUTTONS-1:0] = btnDbnc;
      EDGE_OFF:  rdData[NUM_BUTTONS-1:0] = edgeFlags_q;
      CTRL_OFF:  rdData[MIRROR_BIT]      = ctrlMirror_q;
`ifdef WB_BUTTONS_IRQ_EN
      IMASK_OFF: rdData[NUM_BUTTONS-1:0] = imask_q;
`endif
      default:   rdData = '0;
    endcase
  end

  // A rise seen in the same cycle as a W1C of that bit must survive, so the set term is ORed last.
  always_comb begin
    led_d        = led_q;
    ctrlMirror_d = ctrlMirror_q;
    edgeClr      = '0;
    if (wrEn) begin
      case (offset)
        LED_OFF:  led_d        = wbs.wbs_dat_i[NUM_LEDS-1:0];
        CTRL_OFF: ctrlMirror_d = wbs.wbs_dat_i[MIRROR_BIT];
        EDGE_OFF: edgeClr      = wbs.wbs_dat_i[NUM_BUTTONS-1:0];
        default:  led_d        = led_q;
      endcase
    end
    btnRise     = btnDbnc & ~btnPrev_q;
    edgeFlags_d = (edgeFlags_q & ~edgeClr) | btnRise;
    leds_d      = ctrlMirror_q ? mirrorLeds : led_q;
    ack_d       = access;
    datOut_d    = (access && !wbs.wbs_we_i) ? rdData : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q        <= 1'b0;
      datOut_q     <= '0;
      led_q        <= '0;
      ctrlMirror_q <= 1'b0;
      btnPrev_q    <= '0;
      edgeFlags_q  <= '0;
      leds_q       <= '0;
    end else begin
      ack_q        <= ack_d;
      datOut_q     <= datOut_d;
      led_q        <= led_d;
      ctrlMirror_q <= ctrlMirror_d;
      btnPrev_q    <= btnDbnc;
      edgeFlags_q  <= edgeFlags_d;
      leds_q       <= leds_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = datOut_q;
  assign leds_o        = leds_q;
  assign leds_oeb_o    = '0;

  assign unusedBits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:NUM_LEDS]};

endmodule

// File: tb/tb_wb_buttons_leds_slave.sv
// Directed bench for wb_buttons_leds_slave: register table, held-strobe ack cadence,
// debounce timing, W1C race, mirror mode, optional IRQ and mid-transfer reset.
module tb_wb_buttons_leds_slave;
  import wb_buttons_leds_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NB   = 3;
  localparam int          DC   = 16;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        expAck;
    logic [31:0] expData;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [7:0]    leds;
  logic [7:0]    ledsOeb;
  logic          irq;
  int            nChecks = 0;
  int            nFails = 0;

  wb_buttons_leds_slave_if wbIf ();

  wb_buttons_leds_slave #(
    .BASE_ADDR      (BASE),
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rstn),
    .wbs       (wbIf.slave),
    .buttons_i (buttons),
    .leds_o    (leds),
    .leds_oeb_o(ledsOeb),
    .irq_o     (irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input string n, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel,
                                 input logic expAck, input logic [31:0] expData);
    vec_t v;
    v.name = n; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.expAck = expAck; v.expData = expData;
    return v;
  endfunction

  // Single transfer, started at the current time (expected just after a rising edge)
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output bit acked, output int lat);
    wbIf.wbs_cyc_i = 1'b1;
    wbIf.wbs_stb_i = 1'b1;
    wbIf.wbs_we_i  = we;
    wbIf.wbs_adr_i = adr;
    wbIf.wbs_dat_i = dat;
    wbIf.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = '0;
    lat   = 0;
    for (int c = 1; c <= 4 && !acked; c++) begin
      @(posedge clk); #1;
      if (wbIf.wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rd    = wbIf.wbs_dat_o;
        lat   = c;
      end
    end
    wbIf.wbs_cyc_i = 1'b0;
    wbIf.wbs_stb_i = 1'b0;
    wbIf.wbs_we_i  = 1'b0;
  endtask

  // Transfer plus one idle cycle, checked against the vector's expectations
  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    bit          acked;
    int          lat;
    xfer(v.we, v.adr, v.dat, v.sel, rd, acked, lat);
    @(posedge clk); #1;
    checkOutput({v.name, " ack"}, 32'(acked), 32'(v.expAck));
    if (acked) begin
      checkOutput({v.name, " ack latency"}, lat, 1);
      if (!v.we) checkOutput({v.name, " data"}, rd, v.expData);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd;
    bit          acked;
    int          lat;
    int          bad;
    logic [5:0]  ackPattern;

    wbIf.wbs_cyc_i = 1'b0;
    wbIf.wbs_stb_i = 1'b0;
    wbIf.wbs_we_i  = 1'b0;
    wbIf.wbs_sel_i = '0;
    wbIf.wbs_adr_i = '0;
    wbIf.wbs_dat_i = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ack", 32'(wbIf.wbs_ack_o), 0);
    checkOutput("reset dat_o", wbIf.wbs_dat_o, 0);
    checkOutput("reset leds", 32'(leds), 0);
    checkOutput("reset leds_oeb", 32'(ledsOeb), 0);
    checkOutput("reset irq", 32'(irq), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Register map vectors
    vecs.push_back(mkVec("led wr a5",       1'b1, BASE + LED_OFF,  32'h0000_00A5, 4'b0001, 1'b1, 32'h0));
    vecs.push_back(mkVec("led rd",          1'b0, BASE + LED_OFF,  32'h0,         4'b1111, 1'b1, 32'h0000_00A5));
    vecs.push_back(mkVec("led wr sel0",     1'b1, BASE + LED_OFF,  32'h0000_003C, 4'b0000, 1'b1, 32'h0));
    vecs.push_back(mkVec("led rd kept",     1'b0, BASE + LED_OFF,  32'h0,         4'b1111, 1'b1, 32'h0000_00A5));
    vecs.push_back(mkVec("btn rd idle",     1'b0, BASE + BTN_OFF,  32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("edge rd idle",    1'b0, BASE + EDGE_OFF, 32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("ctrl wr sel0",    1'b1, BASE + CTRL_OFF, 32'h0000_0001, 4'b0000, 1'b1, 32'h0));
    vecs.push_back(mkVec("ctrl rd 0",       1'b0, BASE + CTRL_OFF, 32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("ctrl wr 1",       1'b1, BASE + CTRL_OFF, 32'hFFFF_FFFF, 4'b0001, 1'b1, 32'h0));
    vecs.push_back(mkVec("ctrl rd 1",       1'b0, BASE + CTRL_OFF, 32'h0,         4'b1111, 1'b1, 32'h0000_0001));
    vecs.push_back(mkVec("ctrl wr 0",       1'b1, BASE + CTRL_OFF, 32'h0,         4'b0001, 1'b1, 32'h0));
    vecs.push_back(mkVec("ctrl rd 0 again", 1'b0, BASE + CTRL_OFF, 32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("unmapped rd",     1'b0, BASE + 32'h20,   32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("unmapped wr",     1'b1, BASE + 32'h24,   32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("window top rd",   1'b0, BASE + 32'hFC,   32'h0,         4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("imask rd reset",  1'b0, BASE + IMASK_OFF, 32'h0,        4'b1111, 1'b1, 32'h0));
    vecs.push_back(mkVec("outside rd",      1'b0, BASE + 32'h100,  32'h0,         4'b1111, 1'b0, 32'h0));
    vecs.push_back(mkVec("other base wr",   1'b1, 32'h2000_0000,   32'h0000_0011, 4'b0001, 1'b0, 32'h0));
    vecs.push_back(mkVec("led rd final",    1'b0, BASE + LED_OFF,  32'h0,         4'b1111, 1'b1, 32'h0000_00A5));
    foreach (vecs[i]) applyStimulus(vecs[i]);
    checkOutput("leds software", 32'(leds), 32'h0000_00A5);

    // Held strobe: ack every other cycle, data only alongside ack
    wbIf.wbs_cyc_i = 1'b1;
    wbIf.wbs_stb_i = 1'b1;
    wbIf.wbs_we_i  = 1'b0;
    wbIf.wbs_adr_i = BASE + LED_OFF;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      ackPattern[c] = wbIf.wbs_ack_o;
      if (wbIf.wbs_dat_o !== (wbIf.wbs_ack_o ? 32'h0000_00A5 : 32'h0)) bad++;
    end
    wbIf.wbs_cyc_i = 1'b0;
    wbIf.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    checkOutput("held stb ack cadence", 32'(ackPattern), 32'b01_0101);
    checkOutput("held stb data cycles", bad, 0);

    // Debounce: short pulse rejected, sustained press lands after 2+DC cycles
    applyStimulus(mkVec("ctrl mirror on", 1'b1, BASE + CTRL_OFF, 32'h1, 4'b0001, 1'b1, 32'h0));
    checkOutput("mirror idle leds", 32'(leds), 0);
    buttons[0] = 1'b1;
    repeat (DC - 2) @(posedge clk);
    #1;
    buttons[0] = 1'b0;
    bad = 0;
    repeat (DC + 6) begin
      @(posedge clk); #1;
      if (leds !== 8'h00) bad++;
    end
    checkOutput("short pulse leds", bad, 0);
    applyStimulus(mkVec("btn rd after pulse", 1'b0, BASE + BTN_OFF, 32'h0, 4'b1111, 1'b1, 32'h0));
    buttons[0] = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1;
    checkOutput("press leds before latency", 32'(leds), 0);
    @(posedge clk); #1;
    checkOutput("press leds at latency", 32'(leds), 32'h49);
    applyStimulus(mkVec("btn rd pressed",  1'b0, BASE + BTN_OFF,  32'h0, 4'b1111, 1'b1, 32'h1));
    applyStimulus(mkVec("edge rd pressed", 1'b0, BASE + EDGE_OFF, 32'h0, 4'b1111, 1'b1, 32'h1));

    // W1C racing a fresh rising edge on the same bit
    buttons[0] = 1'b0;
    repeat (DC + 6) @(posedge clk);
    #1;
    applyStimulus(mkVec("edge rd after release", 1'b0, BASE + EDGE_OFF, 32'h0, 4'b1111, 1'b1, 32'h1));
    buttons[0] = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1;
    xfer(1'b1, BASE + EDGE_OFF, 32'h1, 4'b0001, rd, acked, lat);
    @(posedge clk); #1;
    checkOutput("race w1c ack", 32'(acked), 1);
    applyStimulus(mkVec("edge rd after race", 1'b0, BASE + EDGE_OFF, 32'h0, 4'b1111, 1'b1, 32'h1));
    applyStimulus(mkVec("edge w1c",           1'b1, BASE + EDGE_OFF, 32'h1, 4'b0001, 1'b1, 32'h0));
    applyStimulus(mkVec("edge rd cleared",    1'b0, BASE + EDGE_OFF, 32'h0, 4'b1111, 1'b1, 32'h0));

    // Mirror mode replication
    applyStimulus(mkVec("ctrl mirror again", 1'b1, BASE + CTRL_OFF, 32'h1, 4'b0001, 1'b1, 32'h0));
    buttons = 3'b111;
    repeat (DC + 3) @(posedge clk);
    #1;
    checkOutput("mirror all pressed", 32'(leds), 32'hFF);
    buttons = 3'b010;
    repeat (DC + 3) @(posedge clk);
    #1;
    checkOutput("mirror 010", 32'(leds), 32'h92);
    applyStimulus(mkVec("edge rd mirror", 1'b0, BASE + EDGE_OFF, 32'h0, 4'b1111, 1'b1, 32'h6));

`ifdef WB_BUTTONS_IRQ_EN
    buttons = '0;
    repeat (DC + 6) @(posedge clk);
    #1;
    applyStimulus(mkVec("edge w1c all",  1'b1, BASE + EDGE_OFF,  32'h7, 4'b0001, 1'b1, 32'h0));
    applyStimulus(mkVec("imask wr",      1'b1, BASE + IMASK_OFF, 32'h4, 4'b0001, 1'b1, 32'h0));
    applyStimulus(mkVec("imask rd",      1'b0, BASE + IMASK_OFF, 32'h0, 4'b1111, 1'b1, 32'h4));
    checkOutput("irq idle", 32'(irq), 0);
    buttons = 3'b100;
    repeat (DC + 3) @(posedge clk);
    #1;
    checkOutput("irq before edge", 32'(irq), 0);
    @(posedge clk); #1;
    checkOutput("irq on button 2", 32'(irq), 1);
    xfer(1'b1, BASE + EDGE_OFF, 32'h4, 4'b0001, rd, acked, lat);
    checkOutput("irq clear ack", 32'(acked), 1);
    checkOutput("irq at clear edge", 32'(irq), 1);
    @(posedge clk); #1;
    checkOutput("irq after clear", 32'(irq), 0);
`else
    checkOutput("irq stays low", 32'(irq), 0);
    applyStimulus(mkVec("imask wr ignored", 1'b1, BASE + IMASK_OFF, 32'h4, 4'b0001, 1'b1, 32'h0));
    applyStimulus(mkVec("imask rd zero",    1'b0, BASE + IMASK_OFF, 32'h0, 4'b1111, 1'b1, 32'h0));
    checkOutput("irq still low", 32'(irq), 0);
`endif

    // Reset in the middle of an acked transfer
    buttons = '0;
    repeat (DC + 6) @(posedge clk);
    #1;
    wbIf.wbs_cyc_i = 1'b1;
    wbIf.wbs_stb_i = 1'b1;
    wbIf.wbs_we_i  = 1'b0;
    wbIf.wbs_adr_i = BASE + LED_OFF;
    @(posedge clk); #1;
    checkOutput("pre-reset ack", 32'(wbIf.wbs_ack_o), 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mid reset ack", 32'(wbIf.wbs_ack_o), 0);
    checkOutput("mid reset dat_o", wbIf.wbs_dat_o, 0);
    checkOutput("mid reset leds", 32'(leds), 0);
    checkOutput("mid reset leds_oeb", 32'(ledsOeb), 0);
    checkOutput("mid reset irq", 32'(irq), 0);
    wbIf.wbs_cyc_i = 1'b0;
    wbIf.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wbIf.wbs_ack_o !== 1'b0) bad++;
    end
    checkOutput("no ack after release", bad, 0);
    applyStimulus(mkVec("post reset led",   1'b0, BASE + LED_OFF,   32'h0, 4'b1111, 1'b1, 32'h0));
    applyStimulus(mkVec("post reset btn",   1'b0, BASE + BTN_OFF,   32'h0, 4'b1111, 1'b1, 32'h0));
    applyStimulus(mkVec("post reset edge",  1'b0, BASE + EDGE_OFF,  32'h0, 4'b1111, 1'b1, 32'h0));
    applyStimulus(mkVec("post reset ctrl",  1'b0, BASE + CTRL_OFF,  32'h0, 4'b1111, 1'b1, 32'h0));
    applyStimulus(mkVec("post reset imask", 1'b0, BASE + IMASK_OFF, 32'h0, 4'b1111, 1'b1, 32'h0));
    checkOutput("post reset leds", 32'(leds), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
